// File: rtl/osd_watch_pkg.sv
// rtl/osd_watch_pkg.sv - shared types for the OSD watch scheduler and print dispatcher
package osd_watch_pkg;

    localparam int OSD_ADDR_W     = 16;
    localparam int OSD_STR_ADDR_W = 16;

    // Command types understood by the dispatcher; 5..7 are unused codes.
    typedef enum logic [2:0] {
        CMD_STR  = 3'd0,
        CMD_UDEC = 3'd1,
        CMD_SDEC = 3'd2,
        CMD_HEX  = 3'd3,
        CMD_BIN  = 3'd4
    } cmd_type_t;

    // Per-slot watch configuration. ctype is kept raw so unused codes can be stored.
    typedef struct packed {
        logic                      en;
        logic [2:0]                ctype;
        logic [OSD_ADDR_W-1:0]     base_addr;
        logic [OSD_STR_ADDR_W-1:0] str_base;
        logic [3:0]                dec_minw;
        logic                      dec_zpad;
        logic                      hex_pfx;
        logic                      hex_uc;
        logic [3:0]                hex_min;
        logic                      bin_pfx;
        logic                      bin_g4;
    } slot_cfg_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_ISSUE = 2'd2
    } sched_state_t;

    // A slot takes part in refresh only when enabled with a type the dispatcher knows.
    function automatic logic is_printable(input slot_cfg_t c);
        return c.en && (c.ctype <= 3'(CMD_BIN));
    endfunction

endpackage

// File: rtl/osd_watch_scheduler_if.sv
// rtl/osd_watch_scheduler_if.sv - command port between watch scheduler and print dispatcher
interface osd_watch_scheduler_if #(
    parameter int WIDTH      = 32,
    parameter int STR_ADDR_W = 16
) ();
    import osd_watch_pkg::*;

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [2:0]            cmd_type;
    logic [OSD_ADDR_W-1:0] base_addr;
    logic [WIDTH-1:0]      value;
    logic [STR_ADDR_W-1:0] str_base_addr;
    logic [3:0]            dec_min_width;
    logic                  dec_zero_pad;
    logic                  hex_prefix_0x;
    logic                  hex_uppercase;
    logic [3:0]            hex_min_nibbles;
    logic                  bin_prefix_0b;
    logic                  bin_group4;

    modport master (
        output cmd_valid, cmd_type, base_addr, value, str_base_addr, dec_min_width,
               dec_zero_pad, hex_prefix_0x, hex_uppercase, hex_min_nibbles,
               bin_prefix_0b, bin_group4,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_type, base_addr, value, str_base_addr, dec_min_width,
               dec_zero_pad, hex_prefix_0x, hex_uppercase, hex_min_nibbles,
               bin_prefix_0b, bin_group4,
        output cmd_ready
    );

endinterface

// File: rtl/osd_rr_pick.sv
// rtl/osd_rr_pick.sv - combinational round-robin first-set finder
module osd_rr_pick #(
    parameter int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] idx,
    output logic         any
);

    // Scan offsets from farthest to nearest so the request closest at/after ptr wins.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req[ptr + W'(k)]) begin
                idx = ptr + W'(k);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/osd_watch_scheduler.sv
// rtl/osd_watch_scheduler.sv - frame-driven refresh scheduler for OSD watch slots
module osd_watch_scheduler
    import osd_watch_pkg::*;
#(
    parameter int NSLOT      = 8,
    parameter int WIDTH      = 32,
    parameter int STR_ADDR_W = OSD_STR_ADDR_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cfg_we,
    input  logic [$clog2(NSLOT)-1:0] cfg_slot,
    input  slot_cfg_t                cfg_data,
    input  logic [NSLOT*WIDTH-1:0]   slot_value,
    input  logic                     frame_tick,
    input  logic                     force_all,
    osd_watch_scheduler_if.master    cmd,
    output logic [NSLOT-1:0]         pending,
    output logic                     busy
);

    localparam int SEL_W = $clog2(NSLOT);

    sched_state_t          r_state;
    sched_state_t          w_state_nxt;

    slot_cfg_t             r_cfg    [NSLOT];
    logic [WIDTH-1:0]      r_shadow [NSLOT];
    logic [NSLOT-1:0]      r_dirty;
    logic [NSLOT-1:0]      r_pending;
    logic [SEL_W-1:0]      r_rr_ptr;
    logic [SEL_W-1:0]      r_sel;

    logic                  r_cmd_valid;
    logic [2:0]            r_cmd_type;
    logic [OSD_ADDR_W-1:0] r_cmd_base;
    logic [WIDTH-1:0]      r_cmd_value;
    logic [STR_ADDR_W-1:0] r_cmd_str;
    logic [3:0]            r_cmd_dec_minw;
    logic                  r_cmd_dec_zpad;
    logic                  r_cmd_hex_pfx;
    logic                  r_cmd_hex_uc;
    logic [3:0]            r_cmd_hex_min;
    logic                  r_cmd_bin_pfx;
    logic                  r_cmd_bin_g4;

    logic [WIDTH-1:0]      w_val [NSLOT];
    logic [NSLOT-1:0]      w_elig;
    logic [NSLOT-1:0]      w_need;
    logic [NSLOT-1:0]      w_cfg_oh;
    logic [NSLOT-1:0]      w_set;
    logic [NSLOT-1:0]      w_clr_acc;
    logic [NSLOT-1:0]      w_clr_dis;
    logic [NSLOT-1:0]      w_pending_nxt;
    logic [NSLOT-1:0]      w_dirty_nxt;
    logic [SEL_W-1:0]      w_pick_idx;
    logic                  w_pick_any;
    slot_cfg_t             w_pick_cfg;
    logic                  w_load;
    logic                  w_accept;

    for (genvar g = 0; g < NSLOT; g++) begin : g_val
        assign w_val[g] = slot_value[g*WIDTH +: WIDTH];
    end

    osd_rr_pick #(.N(NSLOT)) u_pick (
        .req (r_pending),
        .ptr (r_rr_ptr),
        .idx (w_pick_idx),
        .any (w_pick_any)
    );

    assign w_pick_cfg = r_cfg[w_pick_idx];
    assign w_accept   = (r_state == S_ISSUE) && cmd.cmd_ready;

    // Per-slot refresh need: strings only on config change, values also on drift from shadow.
    always_comb begin
        w_elig = '0;
        w_need = '0;
        for (int i = 0; i < NSLOT; i++) begin
            w_elig[i] = is_printable(r_cfg[i]);
            w_need[i] = w_elig[i] &&
                        (r_dirty[i] || ((r_cfg[i].ctype != 3'(CMD_STR)) && (w_val[i] != r_shadow[i])));
        end
    end

    // Pending/dirty update; new marks win over the accept clear, disabling a slot wins over all.
    always_comb begin
        w_cfg_oh      = cfg_we ? (NSLOT'(1) << cfg_slot) : '0;
        w_set         = (frame_tick ? w_need : '0) | (force_all ? w_elig : '0);
        w_clr_acc     = w_accept ? (NSLOT'(1) << r_sel) : '0;
        w_clr_dis     = (cfg_we && !is_printable(cfg_data)) ? w_cfg_oh : '0;
        w_pending_nxt = ((r_pending & ~w_clr_acc) | w_set) & ~w_clr_dis;
        w_dirty_nxt   = (r_dirty & ~w_clr_acc) | w_cfg_oh;
    end

    // Scheduler state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Scheduler next state: LOAD snapshots one slot, ISSUE waits for the dispatcher.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (|r_pending) w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                if (w_pick_any) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_ISSUE;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (w_accept) w_state_nxt = (|w_pending_nxt) ? S_LOAD : S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Slot tables, round-robin pointer and the in-flight command snapshot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NSLOT; i++) begin
                r_cfg[i]    <= '0;
                r_shadow[i] <= '0;
            end
            r_dirty        <= '0;
            r_pending      <= '0;
            r_rr_ptr       <= '0;
            r_sel          <= '0;
            r_cmd_valid    <= 1'b0;
            r_cmd_type     <= '0;
            r_cmd_base     <= '0;
            r_cmd_value    <= '0;
            r_cmd_str      <= '0;
            r_cmd_dec_minw <= '0;
            r_cmd_dec_zpad <= 1'b0;
            r_cmd_hex_pfx  <= 1'b0;
            r_cmd_hex_uc   <= 1'b0;
            r_cmd_hex_min  <= '0;
            r_cmd_bin_pfx  <= 1'b0;
            r_cmd_bin_g4   <= 1'b0;
        end else begin
            r_pending <= w_pending_nxt;
            r_dirty   <= w_dirty_nxt;
            if (cfg_we) r_cfg[cfg_slot] <= cfg_data;
            if (w_load) begin
                r_sel          <= w_pick_idx;
                r_cmd_valid    <= 1'b1;
                r_cmd_type     <= w_pick_cfg.ctype;
                r_cmd_base     <= w_pick_cfg.base_addr;
                r_cmd_value    <= w_val[w_pick_idx];
                r_cmd_str      <= STR_ADDR_W'(w_pick_cfg.str_base);
                r_cmd_dec_minw <= w_pick_cfg.dec_minw;
                r_cmd_dec_zpad <= w_pick_cfg.dec_zpad;
                r_cmd_hex_pfx  <= w_pick_cfg.hex_pfx;
                r_cmd_hex_uc   <= w_pick_cfg.hex_uc;
                r_cmd_hex_min  <= w_pick_cfg.hex_min;
                r_cmd_bin_pfx  <= w_pick_cfg.bin_pfx;
                r_cmd_bin_g4   <= w_pick_cfg.bin_g4;
            end
            if (w_accept) begin
                r_cmd_valid     <= 1'b0;
                r_shadow[r_sel] <= r_cmd_value;
                r_rr_ptr        <= r_sel + 1'b1;
            end
        end
    end

    assign cmd.cmd_valid       = r_cmd_valid;
    assign cmd.cmd_type        = r_cmd_type;
    assign cmd.base_addr       = r_cmd_base;
    assign cmd.value           = r_cmd_value;
    assign cmd.str_base_addr   = r_cmd_str;
    assign cmd.dec_min_width   = r_cmd_dec_minw;
    assign cmd.dec_zero_pad    = r_cmd_dec_zpad;
    assign cmd.hex_prefix_0x   = r_cmd_hex_pfx;
    assign cmd.hex_uppercase   = r_cmd_hex_uc;
    assign cmd.hex_min_nibbles = r_cmd_hex_min;
    assign cmd.bin_prefix_0b   = r_cmd_bin_pfx;
    assign cmd.bin_group4      = r_cmd_bin_g4;

    assign pending = r_pending;
    assign busy    = (r_state != S_IDLE) || (|r_pending);

endmodule

// File: tb/tb_osd_watch_scheduler.sv
// tb/tb_osd_watch_scheduler.sv - randomized self-checking bench for osd_watch_scheduler
module tb_osd_watch_scheduler;
    import osd_watch_pkg::*;

    localparam int NSLOT = 8;
    localparam int WIDTH = 32;
    localparam int SW    = 3;

    logic                   clk        = 1'b0;
    logic                   rst_n      = 1'b0;
    logic                   cfg_we     = 1'b0;
    logic [SW-1:0]          cfg_slot   = '0;
    slot_cfg_t              cfg_data   = '0;
    logic [NSLOT*WIDTH-1:0] slot_value = '0;
    logic                   frame_tick = 1'b0;
    logic                   force_all  = 1'b0;
    logic [NSLOT-1:0]       pending;
    logic                   busy;

    logic rdy_rand = 1'b0;
    logic rdy_val  = 1'b1;
    logic rnd_bit  = 1'b0;

    osd_watch_scheduler_if #(.WIDTH(WIDTH), .STR_ADDR_W(16)) cmd_bus ();

    osd_watch_scheduler #(.NSLOT(NSLOT), .WIDTH(WIDTH), .STR_ADDR_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cfg_we     (cfg_we),
        .cfg_slot   (cfg_slot),
        .cfg_data   (cfg_data),
        .slot_value (slot_value),
        .frame_tick (frame_tick),
        .force_all  (force_all),
        .cmd        (cmd_bus),
        .pending    (pending),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) rnd_bit <= 1'($urandom_range(0, 1));
    assign cmd_bus.cmd_ready = rdy_rand ? rnd_bit : rdy_val;

    int n_pass  = 0;
    int n_total = 0;

    logic [79:0] mon_q  [$];
    logic [79:0] last_q [$];

    // Reference model: slot tables and round-robin pointer as plain arrays.
    slot_cfg_t   m_cfg    [NSLOT];
    logic [31:0] m_shadow [NSLOT];
    bit          m_dirty  [NSLOT];
    bit          m_pend   [NSLOT];
    int          m_ptr;

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [79:0] cur_vec();
        return {cmd_bus.cmd_type, cmd_bus.base_addr, cmd_bus.value, cmd_bus.str_base_addr,
                cmd_bus.dec_min_width, cmd_bus.dec_zero_pad, cmd_bus.hex_prefix_0x,
                cmd_bus.hex_uppercase, cmd_bus.hex_min_nibbles, cmd_bus.bin_prefix_0b,
                cmd_bus.bin_group4};
    endfunction

    function automatic logic [79:0] exp_vec(input slot_cfg_t c, input logic [31:0] v);
        return {c.ctype, c.base_addr, v, c.str_base, c.dec_minw, c.dec_zpad, c.hex_pfx,
                c.hex_uc, c.hex_min, c.bin_pfx, c.bin_g4};
    endfunction

    always @(negedge clk) begin
        if (rst_n && cmd_bus.cmd_valid && cmd_bus.cmd_ready) mon_q.push_back(cur_vec());
    end

    function automatic logic [31:0] val_of(input int i);
        return slot_value[i*WIDTH +: WIDTH];
    endfunction

    function automatic bit m_elig(input int i);
        return m_cfg[i].en && (m_cfg[i].ctype <= 3'd4);
    endfunction

    function automatic int m_next();
        for (int k = 0; k < NSLOT; k++) if (m_pend[(m_ptr + k) % NSLOT]) return (m_ptr + k) % NSLOT;
        return -1;
    endfunction

    function automatic slot_cfg_t mk_cfg(input bit en, input int t, input int base);
        slot_cfg_t c;
        c.en        = en;
        c.ctype     = 3'(t);
        c.base_addr = 16'(base);
        c.str_base  = 16'($urandom);
        c.dec_minw  = 4'($urandom);
        c.dec_zpad  = 1'($urandom);
        c.hex_pfx   = 1'($urandom);
        c.hex_uc    = 1'($urandom);
        c.hex_min   = 4'($urandom);
        c.bin_pfx   = 1'($urandom);
        c.bin_g4    = 1'($urandom);
        return c;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NSLOT; i++) begin
            m_cfg[i]    = '0;
            m_shadow[i] = '0;
            m_dirty[i]  = 1'b0;
            m_pend[i]   = 1'b0;
        end
        m_ptr = 0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; cfg_we = 1'b0; frame_tick = 1'b0; force_all = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();
        model_reset();
        mon_q.delete();
    endtask

    task automatic set_val(input int s, input logic [31:0] v);
        slot_value[s*WIDTH +: WIDTH] = v;
    endtask

    task automatic write_cfg(input int s, input slot_cfg_t c);
        cfg_we = 1'b1; cfg_slot = SW'(s); cfg_data = c;
        step();
        cfg_we = 1'b0;
        m_cfg[s]   = c;
        m_dirty[s] = 1'b1;
        if (!m_elig(s)) m_pend[s] = 1'b0;
    endtask

    task automatic pulse(input bit t, input bit f);
        for (int i = 0; i < NSLOT; i++) begin
            if (t && m_elig(i) && (m_dirty[i] || (m_cfg[i].ctype != 3'd0 && val_of(i) != m_shadow[i])))
                m_pend[i] = 1'b1;
            if (f && m_elig(i)) m_pend[i] = 1'b1;
        end
        frame_tick = t; force_all = f;
        step();
        frame_tick = 1'b0; force_all = 1'b0;
    endtask

    task automatic wait_valid(input string tag);
        for (int k = 0; k < 40 && !cmd_bus.cmd_valid; k++) step();
        check_eq(tag, cmd_bus.cmd_valid, 1'b1);
    endtask

    // Let the DUT drain, then serve the model's pending slots in round-robin order and compare.
    task automatic settle(input string tag);
        logic [79:0] exp_q [$];
        int          i;
        for (int k = 0; k < 400 && busy; k++) step();
        check_eq({tag, "_idle"}, busy, 1'b0);
        while (m_next() >= 0) begin
            i = m_next();
            exp_q.push_back(exp_vec(m_cfg[i], val_of(i)));
            m_shadow[i] = val_of(i);
            m_dirty[i]  = 1'b0;
            m_pend[i]   = 1'b0;
            m_ptr       = (i + 1) % NSLOT;
        end
        check_eq({tag, "_count"}, mon_q.size(), exp_q.size());
        for (int k = 0; k < exp_q.size() && k < mon_q.size(); k++)
            check_eq($sformatf("%s_cmd%0d", tag, k), mon_q[k], exp_q[k]);
        check_eq({tag, "_pending"}, pending, '0);
        last_q = mon_q;
        mon_q.delete();
    endtask

    slot_cfg_t   c;
    logic [79:0] snap;

    initial begin
        model_reset();
        // Reset state
        step();
        check_eq("rst_valid", cmd_bus.cmd_valid, 1'b0);
        check_eq("rst_fields", cur_vec(), '0);
        check_eq("rst_pending", pending, '0);
        check_eq("rst_busy", busy, 1'b0);
        do_reset();

        // Single HEX slot, then unchanged and changed value
        c = mk_cfg(1'b1, 3, 16'h0040);
        write_cfg(2, c);
        set_val(2, 32'h1234);
        pulse(1'b1, 1'b0);
        settle("t1");
        if (last_q.size() == 1) check_eq("t1_value", last_q[0][60:29], 32'h1234);
        pulse(1'b1, 1'b0);
        settle("t2_same");
        set_val(2, 32'h1235);
        pulse(1'b1, 1'b0);
        settle("t2_diff");
        if (last_q.size() == 1) check_eq("t2_value", last_q[0][60:29], 32'h1235);

        // Round-robin order from pointer 4
        do_reset();
        write_cfg(3, mk_cfg(1'b1, 1, 16'h0103));
        pulse(1'b1, 1'b0);
        settle("t3_pre");
        write_cfg(0, mk_cfg(1'b1, 1, 16'h0100));
        write_cfg(5, mk_cfg(1'b1, 1, 16'h0105));
        for (int r = 0; r < 2; r++) begin
            pulse(1'b0, 1'b1);
            settle($sformatf("t3_force%0d", r));
            if (last_q.size() == 3) begin
                check_eq("t3_first", last_q[0][76:61], 16'h0105);
                check_eq("t3_second", last_q[1][76:61], 16'h0100);
                check_eq("t3_third", last_q[2][76:61], 16'h0103);
            end
        end

        // Backpressure keeps the snapshot stable
        do_reset();
        c = mk_cfg(1'b1, 3, 16'h0011);
        write_cfg(1, c);
        set_val(1, 32'hCAFE0001);
        rdy_val = 1'b0;
        pulse(1'b1, 1'b0);
        wait_valid("t4_valid");
        snap = cur_vec();
        check_eq("t4_snap", snap, exp_vec(c, 32'hCAFE0001));
        for (int k = 0; k < 10; k++) begin
            set_val(1, $urandom);
            step();
            check_eq("t4_hold_valid", cmd_bus.cmd_valid, 1'b1);
            check_eq("t4_hold_fields", cur_vec(), snap);
        end
        rdy_val = 1'b1;
        for (int k = 0; k < 5; k++) step();
        check_eq("t4_count", mon_q.size(), 1);
        if (mon_q.size() >= 1) check_eq("t4_accepted", mon_q[0], snap);

        // Accept and tick in the same cycle with a new value
        do_reset();
        c = mk_cfg(1'b1, 3, 16'h0011);
        write_cfg(1, c);
        set_val(1, 32'hA0);
        pulse(1'b1, 1'b0);
        settle("t5_first");
        set_val(1, 32'hA1);
        rdy_val = 1'b0;
        frame_tick = 1'b1; step(); frame_tick = 1'b0;
        wait_valid("t5_valid");
        check_eq("t5_snap", cur_vec(), exp_vec(c, 32'hA1));
        set_val(1, 32'hA2);
        rdy_val = 1'b1;
        frame_tick = 1'b1; step(); frame_tick = 1'b0;
        check_eq("t5_still_pending", pending[1], 1'b1);
        for (int k = 0; k < 40 && busy; k++) step();
        check_eq("t5_idle", busy, 1'b0);
        check_eq("t5_count", mon_q.size(), 2);
        if (mon_q.size() == 2) begin
            check_eq("t5_val_a", mon_q[0][60:29], 32'hA1);
            check_eq("t5_val_b", mon_q[1][60:29], 32'hA2);
        end
        frame_tick = 1'b1; step(); frame_tick = 1'b0;
        for (int k = 0; k < 6; k++) step();
        check_eq("t5_no_reprint", mon_q.size(), 2);

        // String slot, then reset while a command is waiting
        do_reset();
        c = mk_cfg(1'b1, 0, 16'h0044);
        write_cfg(4, c);
        set_val(4, 32'h10);
        pulse(1'b1, 1'b0);
        settle("t6_once");
        set_val(4, 32'h999);
        pulse(1'b1, 1'b0);
        settle("t6_quiet");
        write_cfg(4, c);
        rdy_val = 1'b0;
        pulse(1'b1, 1'b0);
        wait_valid("t6_valid");
        rst_n = 1'b0;
        #1;
        check_eq("t6_rst_valid", cmd_bus.cmd_valid, 1'b0);
        check_eq("t6_rst_fields", cur_vec(), '0);
        check_eq("t6_rst_pending", pending, '0);
        check_eq("t6_rst_busy", busy, 1'b0);
        rdy_val = 1'b1;
        step(); step();
        rst_n = 1'b1;
        step(); step();
        check_eq("t6_no_xfer", mon_q.size(), 0);

        // Randomized traffic with random backpressure
        do_reset();
        rdy_rand = 1'b1;
        for (int it = 0; it < 40; it++) begin
            int nw;
            bit t;
            bit f;
            nw = $urandom_range(0, 3);
            for (int w = 0; w < nw; w++)
                write_cfg($urandom_range(0, NSLOT - 1),
                          mk_cfg($urandom_range(0, 4) != 0, $urandom_range(0, 7), $urandom));
            for (int s = 0; s < NSLOT; s++)
                if ($urandom_range(0, 2) == 0) set_val(s, $urandom_range(0, 3));
            t = ($urandom_range(0, 3) != 0);
            f = !t || ($urandom_range(0, 3) == 0);
            pulse(t, f);
            settle($sformatf("rnd%0d", it));
        end
        rdy_rand = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
